// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial core operand loader.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package poly_pkg;

    // Default operand / result width.
    localparam int POLY_WIDTH = 16;

    // Operand slot index.
    typedef logic [1:0] op_idx_t;

    // Loader FSM encoding.
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Operand order on the input stream.
    localparam op_idx_t IDX_A = 2'd0;
    localparam op_idx_t IDX_B = 2'd1;
    localparam op_idx_t IDX_C = 2'd2;
    localparam op_idx_t IDX_X = 2'd3;

endpackage

// File: rtl/poly_operand_regs.sv
// Four-slot operand register file (A, B, C, X) written one slot per strobe.
// Latency: written value visible on the slot output the cycle after the strobe.
// Backpressure: none; a slot holds its value until the next write to it.
module poly_operand_regs
    import poly_pkg::*;
#(
    parameter int WIDTH = POLY_WIDTH
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             wr_vld,
    input  op_idx_t          wr_idx,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] opa_dat,
    output logic [WIDTH-1:0] opb_dat,
    output logic [WIDTH-1:0] opc_dat,
    output logic [WIDTH-1:0] opx_dat
);

    // Steer the incoming word into the slot selected by the index.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            opa_dat <= '0;
            opb_dat <= '0;
            opc_dat <= '0;
            opx_dat <= '0;
        end else if (wr_vld) begin
            case (wr_idx)
                IDX_A:   opa_dat <= wr_dat;
                IDX_B:   opb_dat <= wr_dat;
                IDX_C:   opc_dat <= wr_dat;
                default: opx_dat <= wr_dat;
            endcase
        end
    end

endmodule

// File: rtl/poly_operand_loader.sv
// Streams A,B,C,X into the polynomial core, pulses start, captures resultado on done.
// Latency: start the cycle after the 4th operand; res_valid the cycle after done.
// Backpressure: in_ready low from START until the result is taken; result held while res_ready=0.
// Optional: POLY_LOADER_TIMEOUT_EN adds a WAIT-state timeout that returns a zero result with err set.
module poly_operand_loader
    import poly_pkg::*;
#(
    parameter int WIDTH          = POLY_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk0,
    input  logic             rst0,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] Xis,
    output logic             start,
    input  logic [WIDTH-1:0] resultado,
    input  logic             done,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             err
);

    logic [1:0] state;
    op_idx_t    idx;
    logic       wr_en;
    logic       timeout_hit;

    // Status outputs decode directly from the state register.
    assign in_ready  = (state == ST_LOAD);
    assign wr_en     = in_valid & in_ready;
    assign start     = (state == ST_START);
    assign busy      = (state == ST_START) | (state == ST_WAIT);
    assign res_valid = (state == ST_HOLD);

    poly_operand_regs #(
        .WIDTH (WIDTH)
    ) u_regs (
        .core_clk (clk0),
        .arst_n   (rst0),
        .wr_vld   (wr_en),
        .wr_idx   (idx),
        .wr_dat   (in_data),
        .opa_dat  (A),
        .opb_dat  (B),
        .opc_dat  (C),
        .opx_dat  (Xis)
    );

`ifdef POLY_LOADER_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Abort on the edge that closes the TIMEOUT_CYCLES-th WAIT cycle; done takes priority.
    assign timeout_hit = (state == ST_WAIT) && !done && (wait_cnt == CNT_LAST);
    assign err         = err_q;

    // Count cycles spent in WAIT; any other state holds the counter at zero.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Error flag raised by the timeout, cleared when the consumer takes the result.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if ((state == ST_HOLD) && res_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    // Without the timeout WAIT never aborts; a negative timeout is meaningless, so err is 0.
    localparam logic ERR_TIE = (TIMEOUT_CYCLES < 0);

    assign timeout_hit = 1'b0;
    assign err         = ERR_TIE;
`endif

    // Job sequencer: load four words, pulse start, wait for done, hold result until taken.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            state    <= ST_LOAD;
            idx      <= IDX_A;
            res_data <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (wr_en) begin
                        idx <= idx + 2'd1;
                        if (idx == IDX_X) begin
                            state <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        res_data <= resultado;
                        state    <= ST_HOLD;
                    end else if (timeout_hit) begin
                        res_data <= '0;
                        state    <= ST_HOLD;
                    end
                end
                default: begin
                    if (res_ready) begin
                        idx   <= IDX_A;
                        state <= ST_LOAD;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_operand_loader.sv
`timescale 1ns/1ps
module tb_poly_operand_loader;

    localparam int W  = 16;
    localparam int TO = 8;

    logic         clk0 = 1'b0;
    logic         rst0;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B, C, Xis;
    logic         start;
    logic [W-1:0] resultado;
    logic         done;
    logic [W-1:0] res_data;
    logic         res_valid;
    logic         res_ready;
    logic         busy;
    logic         err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int start_cnt   = 0;
    int done_cyc    = -100;

    // Core model controls.
    logic         core_busy   = 1'b0;
    logic         core_mute   = 1'b0;
    logic         core_glitch = 1'b0;
    int           core_lat    = 5;
    logic [W-1:0] core_r;

    poly_operand_loader #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .Xis       (Xis),
        .start     (start),
        .resultado (resultado),
        .done      (done),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;
    always @(posedge clk0) if (start) start_cnt <= start_cnt + 1;

    // Reference polynomial, straight from the operand words.
    function automatic logic [W-1:0] poly(input logic [W-1:0] a, b, c, x);
        longint r;
        r = longint'(a) * longint'(x) * longint'(x) + longint'(b) * longint'(x) + longint'(c);
        return r[W-1:0];
    endfunction

    // Polynomial core model: latches operands on start, answers after core_lat cycles.
    initial begin
        done      = 1'b0;
        resultado = W'($urandom);
        forever begin
            @(negedge clk0);
            if (start && rst0 && !core_mute) begin
                core_busy = 1'b1;
                core_r    = poly(A, B, C, Xis);
                if (core_glitch) begin
                    done      = 1'b1;
                    resultado = 16'hDEAD;
                end
                repeat (core_lat - 1) begin
                    @(negedge clk0);
                    done      = 1'b0;
                    resultado = W'($urandom);
                end
                done      = 1'b1;
                resultado = core_r;
                done_cyc  = cyc;
                @(negedge clk0);
                done      = 1'b0;
                resultado = W'($urandom);
                core_busy = 1'b0;
            end
        end
    end

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one word and return on the negedge after it was accepted; in_valid stays high.
    task automatic send(input logic [W-1:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 100) begin
            @(negedge clk0);
            n++;
        end
        chkb("send_in_ready", in_ready, 1'b1);
        @(negedge clk0);
    endtask

    task automatic chk_cleared(input string tag);
        chkw({tag, "_A"}, A, '0);
        chkw({tag, "_B"}, B, '0);
        chkw({tag, "_C"}, C, '0);
        chkw({tag, "_X"}, Xis, '0);
        chkw({tag, "_res_data"}, res_data, '0);
        chkb({tag, "_start"}, start, 1'b0);
        chkb({tag, "_res_valid"}, res_valid, 1'b0);
        chkb({tag, "_busy"}, busy, 1'b0);
        chkb({tag, "_err"}, err, 1'b0);
    endtask

    // Full job: load with optional gaps, check start timing, result and hold behaviour.
    task automatic run_job(input logic [W-1:0] a, b, c, x, input int gap, input int hold);
        logic [W-1:0] w[4];
        logic [W-1:0] exp;
        int           s0;
        int           n;
        bit           stable;
        w      = '{a, b, c, x};
        exp    = poly(a, b, c, x);
        s0     = start_cnt;
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(w[i]);
            if (i < 3 && gap > 0) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                repeat (gap) begin
                    if (start || !in_ready) stable = 1'b0;
                    @(negedge clk0);
                end
            end
        end
        in_valid = 1'b0;
        in_data  = W'($urandom);
        chkb("start_after_4th", start, 1'b1);
        chkb("busy_in_start", busy, 1'b1);
        chkb("in_ready_in_start", in_ready, 1'b0);
        chkw("op_A", A, a);
        chkw("op_B", B, b);
        chkw("op_C", C, c);
        chkw("op_X", Xis, x);
        @(negedge clk0);
        chkb("start_one_cycle", start, 1'b0);
        chkb("busy_in_wait", busy, 1'b1);
        n = 0;
        while (!res_valid && n < 100) begin
            if ({A, B, C, Xis} !== {a, b, c, x} || in_ready || start) stable = 1'b0;
            @(negedge clk0);
            n++;
        end
        chkb("res_valid_arrives", res_valid, 1'b1);
        chki("res_latency", cyc, done_cyc + 1);
        chkw("res_data", res_data, exp);
        chkb("busy_in_hold", busy, 1'b0);
        chkb("err_in_hold", err, 1'b0);
        in_valid = 1'b1;
        in_data  = W'($urandom);
        repeat (hold) begin
            if (!res_valid || res_data !== exp || in_ready) stable = 1'b0;
            if ({A, B, C, Xis} !== {a, b, c, x}) stable = 1'b0;
            @(negedge clk0);
        end
        chkb("job_stable", stable, 1'b1);
        res_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk0);
        res_ready = 1'b0;
        chkb("res_valid_cleared", res_valid, 1'b0);
        chkb("in_ready_back", in_ready, 1'b1);
        chki("start_pulses", start_cnt - s0, 1);
    endtask

    task automatic wait_core_idle();
        int n;
        n = 0;
        while (core_busy && n < 50) begin
            @(negedge clk0);
            n++;
        end
        chkb("core_idle", core_busy, 1'b0);
    endtask

    initial begin
        rst0      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk0);
        chk_cleared("reset");
        rst0 = 1'b1;
        @(negedge clk0);
        chkb("post_reset_in_ready", in_ready, 1'b1);

        // Basic job, gapped input, back-pressured result, back-to-back jobs.
        run_job(16'd3, 16'd10, 16'd5, 16'd3, 0, 0);
        run_job(16'd1, 16'd2, 16'd3, 16'd4, 2, 0);
        run_job(16'd3, 16'd10, 16'd5, 16'd3, 0, 10);
        run_job(16'd3, 16'd10, 16'd5, 16'd3, 0, 0);
        run_job(16'd0, 16'd0, 16'd7, 16'd100, 0, 0);

        // Reset two cycles after start, while the core is still working.
        send(16'd3); send(16'd10); send(16'd5); send(16'd3);
        in_valid = 1'b0;
        chkb("rst_job_start", start, 1'b1);
        repeat (2) @(negedge clk0);
        rst0 = 1'b0;
        #1;
        chk_cleared("mid_wait_rst");
        repeat (2) @(negedge clk0);
        rst0 = 1'b1;
        @(negedge clk0);
        chkb("rst_release_in_ready", in_ready, 1'b1);
        wait_core_idle();

        // Partially loaded operands are discarded by reset.
        send(16'd7); send(16'd8);
        in_valid = 1'b0;
        rst0     = 1'b0;
        #1;
        chk_cleared("partial_rst");
        @(negedge clk0);
        rst0 = 1'b1;
        @(negedge clk0);
        run_job(16'd3, 16'd10, 16'd5, 16'd3, 0, 0);

        // Randomised jobs: random operands, gaps, holds, core latency, spurious done in START.
        for (int j = 0; j < 10; j++) begin
            core_lat    = $urandom_range(2, 8);
            core_glitch = 1'($urandom_range(0, 1));
            run_job(W'($urandom), W'($urandom), W'($urandom),
                    (j == 0) ? 16'd0 : (j == 1) ? 16'hFFFF : W'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 4));
        end
        core_glitch = 1'b0;
        core_lat    = 5;

`ifdef POLY_LOADER_TIMEOUT_EN
        // Core never answers: abort after exactly TO cycles in WAIT.
        core_mute = 1'b1;
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        in_valid = 1'b0;
        chkb("to_start", start, 1'b1);
        repeat (TO) @(negedge clk0);
        chkb("to_err_not_early", err, 1'b0);
        chkb("to_valid_not_early", res_valid, 1'b0);
        @(negedge clk0);
        chkb("to_err", err, 1'b1);
        chkb("to_res_valid", res_valid, 1'b1);
        chkw("to_res_data", res_data, '0);
        chkb("to_busy", busy, 1'b0);
        res_ready = 1'b1;
        @(negedge clk0);
        res_ready = 1'b0;
        chkb("to_err_cleared", err, 1'b0);
        chkb("to_res_valid_cleared", res_valid, 1'b0);
        chkb("to_in_ready", in_ready, 1'b1);
        core_mute = 1'b0;
        run_job(16'd3, 16'd10, 16'd5, 16'd3, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
